// File: rtl/fatori_mon_pkg.sv
// Shared types for the fatori voter error monitor and its arbiter.
package fatori_mon_pkg;

  typedef enum logic [1:0] {
    MIN   = 2'b00,
    MAJ   = 2'b01,
    SCRUB = 2'b10
  } evt_kind_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ESC  = 2'b01,
    COOL = 2'b10
  } esc_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fatori_mon_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer;
// the pointer moves just past the winner whenever a grant is taken.
module fatori_mon_rr_arb
  import fatori_mon_pkg::*;
#(
  parameter  int unsigned NV = 4,
  localparam int unsigned IW = idx_w(NV)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [NV-1:0] req,
  input  logic          adv,
  output logic          gnt_vld_c,
  output logic [IW-1:0] gnt_idx_c
);

  localparam int unsigned JW = IW + 1;

  logic [IW-1:0] ptr_q;

  // Scan NV positions starting at the pointer, wrapping modulo NV.
  always_comb begin
    logic [JW-1:0] j;
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    j         = '0;
    for (int unsigned i = 0; i < NV; i++) begin
      j = {1'b0, ptr_q} + JW'(i);
      if (j >= JW'(NV)) j = j - JW'(NV);
      if (!gnt_vld_c && req[j[IW-1:0]]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = j[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (adv && gnt_vld_c) begin
      ptr_q <= (gnt_idx_c == IW'(NV - 1)) ? '0 : gnt_idx_c + IW'(1);
    end
  end

endmodule

// File: rtl/fatori_mon_err_arb.sv
// Voter error monitor: edge-detects per-voter error flags, arbitrates them into
// a ready/valid event stream, counts events and escalates on MAJ errors.
// Define FATORI_MON_ERR_SCRUB_EN to report scrub_i edges as SCRUB events.
module fatori_mon_err_arb
  import fatori_mon_pkg::*;
#(
  parameter  int unsigned NV         = 4,
  parameter  int unsigned CNT_W      = 16,
  parameter  int unsigned MAJ_THRESH = 1,
  parameter  int unsigned COOL_CYC   = 8,
  localparam int unsigned IW         = idx_w(NV)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NV-1:0]    min_err_i,
  input  logic [NV-1:0]    maj_err_i,
  input  logic [NV-1:0]    scrub_i,
  input  logic             clr_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IW-1:0]    evt_id_o,
  output logic [1:0]       evt_kind_o,
  output logic [CNT_W-1:0] min_cnt_o,
  output logic [CNT_W-1:0] maj_cnt_o,
  output logic             esc_req_o,
  input  logic             esc_ack_i
);

  localparam int unsigned CW = idx_w(COOL_CYC);
`ifdef FATORI_MON_ERR_SCRUB_EN
  localparam bit SCRUB_EN = 1'b1;
`else
  localparam bit SCRUB_EN = 1'b0;
`endif

  logic [NV-1:0] min_q, maj_q, scr_q;
  logic [NV-1:0] min_set, maj_set, scr_set;
  logic [NV-1:0] pmin_q, pmaj_q, pscr_q;
  logic [NV-1:0] clr_min, clr_maj, clr_scr;
  logic [NV-1:0] any_pend;

  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;
  logic          load, take, accept;
  evt_kind_e     kind_c;

  logic          valid_q;
  logic [IW-1:0] id_q;
  evt_kind_e     kind_q;

  logic [CNT_W-1:0] min_cnt_q, maj_cnt_q;

  esc_state_e    state_q, state_d;
  logic [CW-1:0] cool_q, cool_d;
  logic          esc_req_q;
  logic          ack_clr;

  assign min_set  = min_err_i & ~min_q;
  assign maj_set  = maj_err_i & ~maj_q;
  assign scr_set  = SCRUB_EN ? (scrub_i & ~scr_q) : '0;
  assign any_pend = pmin_q | pmaj_q | pscr_q;

  assign load    = (!valid_q || evt_ready_i) && !clr_i;
  assign take    = load && gnt_vld;
  assign accept  = valid_q && evt_ready_i;
  assign ack_clr = (state_q == ESC) && esc_ack_i;

  fatori_mon_rr_arb #(.NV(NV)) u_rr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req       (any_pend),
    .adv       (load),
    .gnt_vld_c (gnt_vld),
    .gnt_idx_c (gnt_idx)
  );

  // Kind priority inside the granted voter: MAJ, then SCRUB, then MIN.
  always_comb begin
    kind_c  = MIN;
    clr_min = '0;
    clr_maj = '0;
    clr_scr = '0;
    if (take) begin
      if (pmaj_q[gnt_idx]) begin
        kind_c           = MAJ;
        clr_maj[gnt_idx] = 1'b1;
      end else if (pscr_q[gnt_idx]) begin
        kind_c           = SCRUB;
        clr_scr[gnt_idx] = 1'b1;
      end else begin
        clr_min[gnt_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_q <= '0;
      maj_q <= '0;
      scr_q <= '0;
    end else begin
      min_q <= min_err_i;
      maj_q <= maj_err_i;
      scr_q <= scrub_i;
    end
  end

  // A new edge wins over a same-cycle grant clear of the same bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pmin_q <= '0;
      pmaj_q <= '0;
      pscr_q <= '0;
    end else if (clr_i) begin
      pmin_q <= '0;
      pmaj_q <= '0;
      pscr_q <= '0;
    end else begin
      pmin_q <= (pmin_q & ~clr_min) | min_set;
      pmaj_q <= (pmaj_q & ~clr_maj) | maj_set;
      pscr_q <= (pscr_q & ~clr_scr) | scr_set;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      kind_q  <= MIN;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= gnt_vld;
      if (gnt_vld) begin
        id_q   <= gnt_idx;
        kind_q <= kind_c;
      end
    end
  end

  // Saturating counters; clear dominates any same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_cnt_q <= '0;
      maj_cnt_q <= '0;
    end else begin
      if (clr_i) begin
        min_cnt_q <= '0;
      end else if (accept && kind_q == MIN && min_cnt_q != '1) begin
        min_cnt_q <= min_cnt_q + CNT_W'(1);
      end
      if (clr_i || ack_clr) begin
        maj_cnt_q <= '0;
      end else if (accept && kind_q == MAJ && maj_cnt_q != '1) begin
        maj_cnt_q <= maj_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cool_q    <= '0;
      esc_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cool_q    <= cool_d;
      esc_req_q <= (state_d == ESC);
    end
  end

  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    unique case (state_q)
      IDLE: if (maj_cnt_q >= CNT_W'(MAJ_THRESH)) state_d = ESC;
      ESC: begin
        if (esc_ack_i) begin
          state_d = COOL;
          cool_d  = '0;
        end
      end
      COOL: begin
        if (cool_q == CW'(COOL_CYC - 1)) state_d = IDLE;
        else                             cool_d  = cool_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign evt_valid_o = valid_q;
  assign evt_id_o    = id_q;
  assign evt_kind_o  = kind_q;
  assign min_cnt_o   = min_cnt_q;
  assign maj_cnt_o   = maj_cnt_q;
  assign esc_req_o   = esc_req_q;

endmodule

// File: tb/tb_fatori_mon_err_arb.sv
// Scoreboard bench for fatori_mon_err_arb: directed stimulus pushes expected
// events, a negedge monitor pops and compares every accepted event.
module tb_fatori_mon_err_arb;
  import fatori_mon_pkg::*;

  localparam int unsigned NV    = 4;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned IW    = 2;
`ifdef FATORI_MON_ERR_SCRUB_EN
  localparam bit SCR_EN = 1'b1;
`else
  localparam bit SCR_EN = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [NV-1:0]    min_err_i = '0;
  logic [NV-1:0]    maj_err_i = '0;
  logic [NV-1:0]    scrub_i = '0;
  logic             clr_i = 1'b0;
  logic             evt_valid_o;
  logic             evt_ready_i = 1'b0;
  logic [IW-1:0]    evt_id_o;
  logic [1:0]       evt_kind_o;
  logic [CNT_W-1:0] min_cnt_o;
  logic [CNT_W-1:0] maj_cnt_o;
  logic             esc_req_o;
  logic             esc_ack_i = 1'b0;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    kind;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  fatori_mon_err_arb #(
    .NV(NV), .CNT_W(CNT_W), .MAJ_THRESH(2), .COOL_CYC(8)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .min_err_i   (min_err_i),
    .maj_err_i   (maj_err_i),
    .scrub_i     (scrub_i),
    .clr_i       (clr_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_id_o    (evt_id_o),
    .evt_kind_o  (evt_kind_o),
    .min_cnt_o   (min_cnt_o),
    .maj_cnt_o   (maj_cnt_o),
    .esc_req_o   (esc_req_o),
    .esc_ack_i   (esc_ack_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, need finish before 200000");
    $fatal(1);
  end

  // Monitor: stability while stalled, and in-order event scoreboard.
  logic          hold_prev = 1'b0;
  logic          clr_prev = 1'b0;
  logic [IW-1:0] prev_id = '0;
  logic [1:0]    prev_kind = '0;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      hold_prev = 1'b0;
      clr_prev  = 1'b0;
    end else begin
      if (hold_prev && !clr_prev) begin
        total++;
        if (!(evt_valid_o && evt_id_o == prev_id && evt_kind_o == prev_kind)) begin
          bad++;
          $display("FAIL hold_stable: got v=%0b id=%0d kind=%0d, need v=1 id=%0d kind=%0d",
                   evt_valid_o, evt_id_o, evt_kind_o, prev_id, prev_kind);
        end
      end
      if (evt_valid_o && evt_ready_i) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL evt_unexpected: got id=%0d kind=%0d, need no event",
                   evt_id_o, evt_kind_o);
        end else begin
          e = exp_q.pop_front();
          if (evt_id_o != e.id || evt_kind_o != e.kind) begin
            bad++;
            $display("FAIL evt_check: got id=%0d kind=%0d, need id=%0d kind=%0d",
                     evt_id_o, evt_kind_o, e.id, e.kind);
          end
        end
      end
      hold_prev = evt_valid_o && !evt_ready_i;
      clr_prev  = clr_i;
      prev_id   = evt_id_o;
      prev_kind = evt_kind_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, need %0d", name, act, exp);
    end
  endtask

  task automatic push(input int unsigned id, input evt_kind_e k);
    exp_t x;
    x.id   = IW'(id);
    x.kind = k;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    min_err_i   = '0;
    maj_err_i   = '0;
    scrub_i     = '0;
    clr_i       = 1'b0;
    evt_ready_i = 1'b0;
    esc_ack_i   = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    @(negedge clk_i);
    chk("rst_valid", 32'(evt_valid_o), 0);
    chk("rst_id", 32'(evt_id_o), 0);
    chk("rst_kind", 32'(evt_kind_o), 0);
    chk("rst_min_cnt", 32'(min_cnt_o), 0);
    chk("rst_maj_cnt", 32'(maj_cnt_o), 0);
    chk("rst_esc", 32'(esc_req_o), 0);

    // Single MIN pulse: valid two cycles after the edge
    evt_ready_i = 1'b1;
    tick(); min_err_i = 4'b0100; push(2, MIN);
    @(negedge clk_i); chk("lat_t0_valid", 32'(evt_valid_o), 0);
    tick(); min_err_i = '0;
    @(negedge clk_i); chk("lat_t1_valid", 32'(evt_valid_o), 0);
    tick();
    @(negedge clk_i); chk("lat_t2_valid", 32'(evt_valid_o), 1);
    tick();
    @(negedge clk_i);
    chk("lat_min_cnt", 32'(min_cnt_o), 1);
    chk("lat_valid_off", 32'(evt_valid_o), 0);

    // All voters MIN+MAJ at once: MAJ 0..3 then MIN 0..3 back to back
    do_reset();
    evt_ready_i = 1'b1;
    tick(); min_err_i = '1; maj_err_i = '1;
    for (int i = 0; i < 4; i++) push(i, MAJ);
    for (int i = 0; i < 4; i++) push(i, MIN);
    tick(); min_err_i = '0; maj_err_i = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clk_i); chk("burst_valid", 32'(evt_valid_o), 1);
    end
    tick();
    @(negedge clk_i);
    chk("burst_done", 32'(evt_valid_o), 0);
    chk("burst_min_sat", 32'(min_cnt_o), 3);
    chk("burst_maj_sat", 32'(maj_cnt_o), 3);
    chk("burst_esc", 32'(esc_req_o), 1);

    // Back-pressure: output held, counters frozen until accept
    do_reset();
    tick(); min_err_i = 4'b0010; push(1, MIN);
    tick(); min_err_i = '0;
    tick();
    @(negedge clk_i); chk("bp_valid", 32'(evt_valid_o), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin maj_err_i = 4'b1000; push(3, MAJ); end
      if (i == 1) maj_err_i = '0;
      @(negedge clk_i);
      chk("bp_min_cnt", 32'(min_cnt_o), 0);
      chk("bp_maj_cnt", 32'(maj_cnt_o), 0);
    end
    tick(); evt_ready_i = 1'b1;
    repeat (2) tick();
    @(negedge clk_i);
    chk("bp_min_after", 32'(min_cnt_o), 1);
    chk("bp_maj_after", 32'(maj_cnt_o), 1);
    chk("bp_drained", 32'(evt_valid_o), 0);

    // Escalation with threshold 2, ack, cooldown, re-trigger
    do_reset();
    evt_ready_i = 1'b1;
    tick(); maj_err_i = 4'b0011; push(0, MAJ); push(1, MAJ);
    tick(); maj_err_i = '0;
    repeat (3) tick();
    @(negedge clk_i);
    chk("esc_maj_cnt", 32'(maj_cnt_o), 2);
    chk("esc_pre", 32'(esc_req_o), 0);
    tick();
    @(negedge clk_i); chk("esc_req", 32'(esc_req_o), 1);
    repeat (2) tick();
    @(negedge clk_i); chk("esc_hold", 32'(esc_req_o), 1);
    tick(); esc_ack_i = 1'b1;
    @(negedge clk_i); chk("esc_ack_cyc", 32'(esc_req_o), 1);
    tick(); esc_ack_i = 1'b0; maj_err_i = 4'b1100; push(2, MAJ); push(3, MAJ);
    @(negedge clk_i);
    chk("esc_cleared", 32'(esc_req_o), 0);
    chk("esc_maj_zero", 32'(maj_cnt_o), 0);
    tick(); maj_err_i = '0;
    for (int k = 3; k <= 9; k++) begin
      tick();
      @(negedge clk_i); chk("cool_no_esc", 32'(esc_req_o), 0);
    end
    chk("cool_maj_counted", 32'(maj_cnt_o), 2);
    tick();
    @(negedge clk_i); chk("esc_retrigger", 32'(esc_req_o), 1);

    // Saturation at 3, clear with same-cycle accept, clear drops output
    do_reset();
    evt_ready_i = 1'b1;
    tick(); min_err_i = '1;
    push(0, MIN); push(1, MIN); push(2, MIN); push(3, MIN); push(0, MIN);
    tick(); min_err_i = '0;
    tick(); min_err_i = 4'b0001;
    tick(); min_err_i = '0;
    repeat (4) tick();
    @(negedge clk_i);
    chk("sat_min_cnt", 32'(min_cnt_o), 3);
    chk("sat_idle", 32'(evt_valid_o), 0);
    tick(); min_err_i = 4'b0010; push(1, MIN);
    tick(); min_err_i = '0;
    tick(); clr_i = 1'b1;
    @(negedge clk_i);
    chk("clr_acc_valid", 32'(evt_valid_o), 1);
    chk("clr_pre_cnt", 32'(min_cnt_o), 3);
    tick(); clr_i = 1'b0; evt_ready_i = 1'b0; min_err_i = 4'b0100;
    @(negedge clk_i); chk("clr_min_zero", 32'(min_cnt_o), 0);
    tick(); min_err_i = '0;
    tick();
    @(negedge clk_i); chk("drop_pre_valid", 32'(evt_valid_o), 1);
    tick(); clr_i = 1'b1;
    tick(); clr_i = 1'b0; evt_ready_i = 1'b1;
    @(negedge clk_i); chk("drop_valid", 32'(evt_valid_o), 0);
    repeat (3) tick();
    @(negedge clk_i); chk("drop_no_replay", 32'(evt_valid_o), 0);

    // Reset during a stalled handshake, then scrub handling
    do_reset();
    tick(); min_err_i = 4'b1000;
    tick(); min_err_i = '0;
    tick();
    @(negedge clk_i); chk("mid_valid", 32'(evt_valid_o), 1);
    tick(); rst_ni = 1'b0; #1;
    chk("mid_rst_valid", 32'(evt_valid_o), 0);
    chk("mid_rst_id", 32'(evt_id_o), 0);
    chk("mid_rst_kind", 32'(evt_kind_o), 0);
    chk("mid_rst_esc", 32'(esc_req_o), 0);
    tick(); tick(); rst_ni = 1'b1; evt_ready_i = 1'b1;
    repeat (5) tick();
    @(negedge clk_i); chk("mid_no_replay", 32'(evt_valid_o), 0);
    tick(); scrub_i = 4'b0010;
    if (SCR_EN) push(1, SCRUB);
    tick(); scrub_i = '0;
    tick();
    @(negedge clk_i); chk("scrub_valid", 32'(evt_valid_o), 32'(SCR_EN));
    repeat (3) tick();
    @(negedge clk_i);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
